coin_payout_sequencer: RTL and testbench
========================================

COIN_PAYOUT_SEQUENCER -- requirements
Module: coin_payout_sequencer

Interface
REQ-001 Parameter SHALL be ACK_TIMEOUT, default 15, max clk2 cycles eject_req may wait for eject_ack.
REQ-002 Parameter SHALL be STOCK_W, default 8, width of each coin stock counter.
REQ-003 clk2  input  1  1 MHz system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a payout of amount; accepted only in IDLE.
REQ-006 amount  input  9  payout value in cents; latched on accepted start.
REQ-007 abort  input  1  stop payout after the coin in flight.
REQ-008 stock_load  input  1  load the three stock counters; accepted only in IDLE.
REQ-009 q_stock_in, d_stock_in, n_stock_in  input  STOCK_W each  quarter, dime and nickel stock load values.
REQ-010 eject_req  output  1  request the coin hopper to eject one coin of eject_sel.
REQ-011 eject_sel  output  2  coin type: 00 quarter, 01 dime, 10 nickel; 11 never driven.
REQ-012 eject_ack  input  1  hopper confirms the selected coin was ejected.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on return to IDLE.
REQ-015 err_short  output  1  sticky: payout ended with remaining >= 5 and no usable coin.
REQ-016 err_jam  output  1  sticky: ack timeout occurred.
REQ-017 remaining  output  9  cents still owed.
REQ-018 q_cnt, d_cnt, n_cnt  output  4 each  coins of each type ejected in the current payout; saturate at 15.
REQ-019 q_stock, d_stock, n_stock  output  STOCK_W each  current stock counters.

Function
REQ-020 FSM states SHALL be IDLE, SELECT, DISPENSE, FINISH.
REQ-021 IDLE + start SHALL latch amount into remaining, clear counts and error flags, and go to SELECT. start takes priority over stock_load in the same cycle.
REQ-022 IDLE + stock_load without start SHALL load all three stock counters. stock_load in any other state SHALL be ignored.
REQ-023 SELECT coin choice SHALL be greedy, in this order: quarter if remaining >= 25 and q_stock > 0; else dime if remaining >= 10 and d_stock > 0; else nickel if remaining >= 5 and n_stock > 0.
REQ-024 SELECT with a coin chosen SHALL register eject_sel, set eject_req, and go to DISPENSE.
REQ-025 SELECT with remaining < 5 SHALL go to FINISH with no error. A residue of 1-4 cents stays in remaining.
REQ-026 SELECT with remaining >= 5 and no coin chosen SHALL set err_short and go to FINISH.
REQ-027 SELECT with abort high SHALL go to FINISH without ejecting a coin.
REQ-028 eject_req SHALL stay high and eject_sel stable through DISPENSE until eject_ack is sampled high.
REQ-029 On eject_ack in DISPENSE, in the same edge: eject_req drops; remaining reduces by the coin value (25/10/5); the stock counter decrements; the count increments; state goes to SELECT.
REQ-030 eject_req SHALL be low for at least one cycle between coins.
REQ-031 Latency: start sampled at edge k gives eject_req high after edge k+1.
REQ-032 eject_ack outside DISPENSE SHALL be ignored.
REQ-033 abort in DISPENSE SHALL be remembered. After the in-flight coin is acked, the FSM SHALL go to FINISH, not SELECT.
REQ-034 The DISPENSE wait counter SHALL reset on entry. If ACK_TIMEOUT cycles elapse without eject_ack, the block SHALL drop eject_req, set err_jam, leave stock, counts and remaining unchanged, and go to FINISH.
REQ-035 FINISH SHALL pulse done for one cycle and return to IDLE the next edge.
REQ-036 err_short and err_jam SHALL hold until the next accepted start or rst.
REQ-037 Stock counters SHALL never underflow; a zero-stock coin type is never selected.
REQ-038 start while busy SHALL be ignored.

Reset
REQ-039 rst SHALL force IDLE and clear all outputs and internal registers to 0: eject_req, eject_sel, busy, done, err_short, err_jam, remaining, counts, stocks, and the wait counter.
REQ-040 rst asserted mid-DISPENSE SHALL drop eject_req on the same edge. It takes priority over eject_ack, start and stock_load.

Verification
REQ-041 Stock loaded 10/10/10, start amount=65, ack 2 cycles after each req -> sequence quarter, quarter, dime, nickel; q/d/n_cnt=2/1/1; stock 8/9/9; remaining=0; done pulses once; no errors.
REQ-042 Stock 0/1/0, amount=30 -> one dime ejected; remaining=20; err_short=1; done pulses.
REQ-043 Stock 5/5/5, amount=25, eject_ack never asserted -> eject_req high exactly 15 cycles; err_jam=1; q_stock=5; remaining=25; done pulses.
REQ-044 Stock 5/5/5, amount=75, abort pulsed during the first DISPENSE -> exactly one quarter ejected; remaining=50; done pulses; no errors.
REQ-045 Stock 5/5/5, amount=43 -> quarter, dime, nickel ejected; remaining=3; no error. start pulsed mid-payout is ignored.
REQ-046 Stock 5/5/5, rst asserted while eject_req is high -> next cycle all outputs 0 and state IDLE. A later stock_load and start with amount=5 ejects one nickel.

Source files
------------

// File: rtl/coin_payout_sequencer.sv
// coin_payout_sequencer: greedy quarter/dime/nickel payout through a handshaked hopper,
// with stock tracking, ack timeout and abort handling.
module coin_payout_sequencer #(
   parameter int ACK_TIMEOUT = 15,
   parameter int STOCK_W     = 8
) (
   input  logic               clk2,
   input  logic               rst,
   input  logic               start,
   input  logic [8:0]         amount,
   input  logic               abort,
   input  logic               stock_load,
   input  logic [STOCK_W-1:0] q_stock_in,
   input  logic [STOCK_W-1:0] d_stock_in,
   input  logic [STOCK_W-1:0] n_stock_in,
   output logic               eject_req,
   output logic [1:0]         eject_sel,
   input  logic               eject_ack,
   output logic               busy,
   output logic               done,
   output logic               err_short,
   output logic               err_jam,
   output logic [8:0]         remaining,
   output logic [3:0]         q_cnt,
   output logic [3:0]         d_cnt,
   output logic [3:0]         n_cnt,
   output logic [STOCK_W-1:0] q_stock,
   output logic [STOCK_W-1:0] d_stock,
   output logic [STOCK_W-1:0] n_stock
);
   localparam int WW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, FINISH} state_t;
   state_t state, state_nx;
   logic [WW-1:0] wait_cnt;
   logic abort_seen, q_ok, d_ok, n_ok, coin_ok, acked, timed_out;
   logic [1:0] sel_nx;
   logic [8:0] coin_val;

   always_comb begin
      q_ok      = remaining >= 9'd25 && q_stock != '0;
      d_ok      = remaining >= 9'd10 && d_stock != '0;
      n_ok      = remaining >= 9'd5 && n_stock != '0;
      coin_ok   = q_ok || d_ok || n_ok;
      sel_nx    = q_ok ? 2'd0 : d_ok ? 2'd1 : 2'd2;
      coin_val  = eject_sel == 2'd0 ? 9'd25 : eject_sel == 2'd1 ? 9'd10 : 9'd5;
      acked     = state == DISPENSE && eject_ack;
      timed_out = state == DISPENSE && !eject_ack && wait_cnt == WW'(ACK_TIMEOUT - 1);
      busy      = state != IDLE;
      done      = state == FINISH;
      state_nx  = state;
      case (state)
         IDLE:     state_nx = start ? SELECT : IDLE;
         SELECT:   state_nx = (abort || !coin_ok) ? FINISH : DISPENSE;
         DISPENSE: state_nx = acked ? ((abort_seen || abort) ? FINISH : SELECT) : timed_out ? FINISH : DISPENSE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk2) state <= rst ? IDLE : state_nx;

   always_ff @(posedge clk2) begin
      if (rst) begin
         eject_req  <= 1'b0;
         eject_sel  <= 2'd0;
         err_short  <= 1'b0;
         err_jam    <= 1'b0;
         remaining  <= '0;
         q_cnt      <= '0;
         d_cnt      <= '0;
         n_cnt      <= '0;
         q_stock    <= '0;
         d_stock    <= '0;
         n_stock    <= '0;
         wait_cnt   <= '0;
         abort_seen <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            remaining  <= amount;
            q_cnt      <= '0;
            d_cnt      <= '0;
            n_cnt      <= '0;
            err_short  <= 1'b0;
            err_jam    <= 1'b0;
            abort_seen <= 1'b0;
         end else if (state == IDLE && stock_load) begin
            q_stock <= q_stock_in;
            d_stock <= d_stock_in;
            n_stock <= n_stock_in;
         end
         if (state == SELECT && state_nx == DISPENSE) begin
            eject_sel  <= sel_nx;
            eject_req  <= 1'b1;
            wait_cnt   <= '0;
            abort_seen <= 1'b0;
         end
         if (state == SELECT && !abort && !coin_ok && remaining >= 9'd5) err_short <= 1'b1;
         if (state == DISPENSE) begin
            abort_seen <= abort_seen || abort;
            wait_cnt   <= wait_cnt + 1'b1;
            if (acked) begin
               eject_req <= 1'b0;
               remaining <= remaining - coin_val;
               // selection guarantees the chosen stock is non-zero, so no underflow here
               if (eject_sel == 2'd0) begin
                  q_stock <= q_stock - 1'b1;
                  q_cnt   <= q_cnt == 4'hf ? q_cnt : q_cnt + 4'd1;
               end else if (eject_sel == 2'd1) begin
                  d_stock <= d_stock - 1'b1;
                  d_cnt   <= d_cnt == 4'hf ? d_cnt : d_cnt + 4'd1;
               end else begin
                  n_stock <= n_stock - 1'b1;
                  n_cnt   <= n_cnt == 4'hf ? n_cnt : n_cnt + 4'd1;
               end
            end else if (timed_out) begin
               eject_req <= 1'b0;
               err_jam   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_coin_payout_sequencer.sv
// tb_coin_payout_sequencer: directed payouts against a simple hopper responder
// with hand-computed expected coin sequences, counts and flags.
`timescale 1ns/1ps
module tb_coin_payout_sequencer;
   logic clk2 = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, stock_load = 1'b0, eject_ack = 1'b0;
   logic [8:0] amount = '0;
   logic [7:0] q_stock_in = '0, d_stock_in = '0, n_stock_in = '0;
   logic eject_req, busy, done, err_short, err_jam;
   logic [1:0] eject_sel;
   logic [8:0] remaining;
   logic [3:0] q_cnt, d_cnt, n_cnt;
   logic [7:0] q_stock, d_stock, n_stock;
   int checks = 0, failures = 0;
   int req_total = 0, done_total = 0, age = 0;
   int ack_dly = 1, coin_base = 0, done_base = 0, req_base = 0;
   bit ack_en = 1'b0;
   int coins[$];

   coin_payout_sequencer dut (
      .clk2(clk2), .rst(rst), .start(start), .amount(amount), .abort(abort),
      .stock_load(stock_load), .q_stock_in(q_stock_in), .d_stock_in(d_stock_in),
      .n_stock_in(n_stock_in), .eject_req(eject_req), .eject_sel(eject_sel),
      .eject_ack(eject_ack), .busy(busy), .done(done), .err_short(err_short),
      .err_jam(err_jam), .remaining(remaining), .q_cnt(q_cnt), .d_cnt(d_cnt),
      .n_cnt(n_cnt), .q_stock(q_stock), .d_stock(d_stock), .n_stock(n_stock)
   );

   always #500 clk2 = ~clk2;

   // hopper model: acks ack_dly cycles into each request, logs the coin as sel+1
   always @(negedge clk2) begin
      if (eject_req) begin
         req_total++;
         age++;
         if (ack_en && age == ack_dly) begin
            eject_ack = 1'b1;
            coins.push_back(int'(eject_sel) + 1);
         end
      end else begin
         age = 0;
         eject_ack = 1'b0;
      end
      if (done) done_total++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk2);
   endtask

   task automatic load(input logic [7:0] q, input logic [7:0] d, input logic [7:0] n);
      q_stock_in = q;
      d_stock_in = d;
      n_stock_in = n;
      stock_load = 1'b1;
      cyc(1);
      stock_load = 1'b0;
   endtask

   task automatic begin_pay(input logic [8:0] amt, input bit en, input int dly);
      ack_en = en;
      ack_dly = dly;
      coin_base = coins.size();
      done_base = done_total;
      req_base = req_total;
      amount = amt;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin
         cyc(1);
         n++;
      end
      check("idle_reached", busy, 0);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!eject_req && n < 20) begin
         cyc(1);
         n++;
      end
      check("req_seen", eject_req, 1);
   endtask

   function automatic int seq_code();
      int c = 0;
      for (int i = coin_base; i < coins.size(); i++) c = c * 16 + coins[i];
      return c;
   endfunction

   initial begin
      cyc(3);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_req", eject_req, 0);
      check("rst_rem", remaining, 0);
      check("rst_qstock", q_stock, 0);
      check("rst_errs", {err_short, err_jam, done}, 0);

      load(10, 10, 10);
      check("load_q", q_stock, 10);
      begin_pay(65, 1, 2);
      check("sel_busy", busy, 1);
      check("sel_req_low", eject_req, 0);
      cyc(1);
      check("latency_req", eject_req, 1);
      check("first_sel", eject_sel, 0);
      wait_idle();
      check("p65_seq", seq_code(), 32'h1123);
      check("p65_cnts", {q_cnt, d_cnt, n_cnt}, 12'h211);
      check("p65_stock", {q_stock, d_stock, n_stock}, {8'd8, 8'd9, 8'd9});
      check("p65_rem", remaining, 0);
      check("p65_done", done_total - done_base, 1);
      check("p65_errs", {err_short, err_jam}, 0);

      load(0, 1, 0);
      begin_pay(30, 1, 1);
      wait_idle();
      check("short_seq", seq_code(), 32'h2);
      check("short_rem", remaining, 20);
      check("short_err", {err_short, err_jam}, 2'b10);
      check("short_dstock", d_stock, 0);
      check("short_done", done_total - done_base, 1);

      load(5, 5, 5);
      begin_pay(25, 0, 1);
      wait_idle();
      check("jam_req_cycles", req_total - req_base, 15);
      check("jam_err", {err_short, err_jam}, 2'b01);
      check("jam_qstock", q_stock, 5);
      check("jam_qcnt", q_cnt, 0);
      check("jam_rem", remaining, 25);
      check("jam_done", done_total - done_base, 1);

      load(5, 5, 5);
      begin_pay(75, 1, 3);
      wait_req();
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      wait_idle();
      check("abort_seq", seq_code(), 32'h1);
      check("abort_rem", remaining, 50);
      check("abort_q", {q_cnt, q_stock}, {4'd1, 8'd4});
      check("abort_errs", {err_short, err_jam}, 0);
      check("abort_done", done_total - done_base, 1);

      load(5, 5, 5);
      begin_pay(43, 1, 1);
      cyc(3);
      amount = 5;
      start = 1'b1;
      q_stock_in = 9;
      stock_load = 1'b1;
      cyc(1);
      start = 1'b0;
      stock_load = 1'b0;
      wait_idle();
      check("p43_seq", seq_code(), 32'h123);
      check("p43_rem", remaining, 3);
      check("p43_err", err_short, 0);
      check("p43_stock", {q_stock, d_stock, n_stock}, {8'd4, 8'd4, 8'd4});
      check("p43_done", done_total - done_base, 1);

      load(0, 0, 20);
      begin_pay(105, 1, 1);
      wait_idle();
      check("sat_ncnt", n_cnt, 15);
      check("sat_nstock", n_stock, 0);
      check("sat_rem", remaining, 5);
      check("sat_short", err_short, 1);

      load(5, 5, 5);
      begin_pay(25, 0, 1);
      wait_req();
      rst = 1'b1;
      cyc(1);
      check("mrst_req", eject_req, 0);
      check("mrst_busy", busy, 0);
      check("mrst_rem", remaining, 0);
      check("mrst_stock", {q_stock, d_stock, n_stock}, 0);
      rst = 1'b0;
      load(5, 5, 5);
      begin_pay(5, 1, 1);
      wait_idle();
      check("mrst_seq", seq_code(), 32'h3);
      check("mrst_nstock", n_stock, 4);
      check("mrst_rem2", remaining, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
